// File: rtl/bus_port_pkg.sv
// Shared constants and helpers for the bus port endpoint.
// Error-flag bit positions are fixed so software and the bus monitor agree on them.
package bus_port_pkg;

    localparam int unsigned PCKG_SZ_DEF = 16;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned ID_W_DEF    = 8;

    // Widest packet dest_of() can take; callers zero-extend narrower packets.
    localparam int unsigned MAX_PCKG_SZ = 64;

    localparam int unsigned ERR_TX_OVF  = 0;
    localparam int unsigned ERR_RX_OVF  = 1;
    localparam int unsigned ERR_POP_UNF = 2;
    localparam int unsigned ERR_W       = 3;

    // Destination field sits in the top id_w bits of a pckg_sz-bit packet.
    function automatic logic [31:0] dest_of(input logic [MAX_PCKG_SZ-1:0] pkt,
                                            input int unsigned            pckg_sz,
                                            input int unsigned            id_w);
        logic [31:0] mask;
        mask = (id_w >= 32) ? '1 : ((32'd1 << id_w) - 32'd1);
        return 32'(pkt >> (pckg_sz - id_w)) & mask;
    endfunction

endpackage

// File: rtl/port_fifo.sv
// Show-ahead FIFO with occupancy count and overflow/underflow strobes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module port_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_i,
    input  logic [Width-1:0]         wr_data_i,
    input  logic                     rd_i,
    output logic [Width-1:0]         rd_data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     ovf_o,
    output logic                     unf_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    logic empty, full, rd_en, wr_en;

    // Status and handshake qualification from the current pointers.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        rd_en = rd_i && !empty;
        wr_en = wr_i && (!full || rd_en);
    end

    // Next-state for storage and pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AddrW-1:0]] = wr_data_i;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    // State registers; reset discards every queued entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Outputs: head is forced to zero while empty so stale data never leaks.
    always_comb begin
        rd_data_o = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
        valid_o   = !empty;
        full_o    = full;
        count_o   = wr_ptr_q - rd_ptr_q;
        ovf_o     = wr_i && !wr_en;
        unf_o     = rd_i && empty;
    end

endmodule

// File: rtl/bus_port_endpoint.sv
// Device-side endpoint of one bus port: TX FIFO feeding pndng/D_pop/pop,
// RX FIFO capturing push/D_push, sticky error flags.
// Optional macro BUS_PORT_ID_CHECK_EN: RX accepts only packets whose
// destination field equals PORT_ID and counts the rejects in id_drop_cnt.
module bus_port_endpoint
    import bus_port_pkg::*;
#(
    parameter int unsigned PCKG_SZ = PCKG_SZ_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned PORT_ID = 0,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tx_wr,
    input  logic [PCKG_SZ-1:0]       tx_data,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     pndng,
    output logic [PCKG_SZ-1:0]       D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [PCKG_SZ-1:0]       D_push,
    output logic                     rx_valid,
    output logic [PCKG_SZ-1:0]       rx_data,
    input  logic                     rx_rd,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic [ERR_W-1:0]         err_flags
`ifdef BUS_PORT_ID_CHECK_EN
    ,
    output logic [15:0]              id_drop_cnt
`endif
);

    logic tx_ovf, tx_unf;
    logic rx_ovf, rx_unf_unused;
    logic rx_wr;

    logic [ERR_W-1:0] err_q, err_d;

`ifdef BUS_PORT_ID_CHECK_EN
    logic [MAX_PCKG_SZ-1:0] pkt_ext;
    logic                   id_match;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    // Destination filter: only packets addressed to this port reach the RX FIFO.
    always_comb begin
        pkt_ext                = '0;
        pkt_ext[PCKG_SZ-1:0]   = D_push;
        id_match               = (dest_of(pkt_ext, PCKG_SZ, ID_W) == PORT_ID);
        rx_wr                  = push && id_match;
    end

    // Saturating count of pushes rejected by the filter.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (push && !id_match && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign id_drop_cnt = drop_cnt_q;
`else
    // Without the filter every push is offered to the RX FIFO.
    always_comb begin
        rx_wr = push;
    end
`endif

    port_fifo #(
        .Width (PCKG_SZ),
        .Depth (DEPTH)
    ) u_tx_fifo (
        .clk_i     (clock),
        .rst_ni    (reset),
        .wr_i      (tx_wr),
        .wr_data_i (tx_data),
        .rd_i      (pop),
        .rd_data_o (D_pop),
        .valid_o   (pndng),
        .full_o    (tx_full),
        .count_o   (tx_count),
        .ovf_o     (tx_ovf),
        .unf_o     (tx_unf)
    );

    // RX has no full output at the top: the bus cannot be backpressured.
    logic rx_full_unused;

    port_fifo #(
        .Width (PCKG_SZ),
        .Depth (DEPTH)
    ) u_rx_fifo (
        .clk_i     (clock),
        .rst_ni    (reset),
        .wr_i      (rx_wr),
        .wr_data_i (D_push),
        .rd_i      (rx_rd),
        .rd_data_o (rx_data),
        .valid_o   (rx_valid),
        .full_o    (rx_full_unused),
        .count_o   (rx_count),
        .ovf_o     (rx_ovf),
        .unf_o     (rx_unf_unused)
    );

    // Sticky error flags; an empty-FIFO rx_rd is harmless and not reported.
    always_comb begin
        err_d              = err_q;
        err_d[ERR_TX_OVF]  = err_q[ERR_TX_OVF]  | tx_ovf;
        err_d[ERR_RX_OVF]  = err_q[ERR_RX_OVF]  | rx_ovf;
        err_d[ERR_POP_UNF] = err_q[ERR_POP_UNF] | tx_unf;
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_flags = err_q;

endmodule
